oam_dma: RTL and testbench

- Sprite OAM DMA engine: the writer side of the sprite unit's OAM port (oam address, oam data, oam write enable).
- A CPU write to the trigger address latches a page number and stalls the CPU.
- The engine then copies 256 bytes from CPU space page XX00-XXFF into OAM, starting at oam_base and wrapping mod 256, with NES-accurate 513/514 CPU-cycle timing.
- Sits between the CPU bus, the CPU memory arbiter and PPU_sprite.

---
 rtl/ppu_pkg.sv | 16 +
 rtl/oam_dma.sv | 130 +++++++++++++
 tb/tb_oam_dma.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: types and constants shared by the PPU-side blocks.
// Holds the OAM DMA state encoding and register map constants.
package ppu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } dma_state_t;

   localparam logic [15:0] OAM_DMA_REG = 16'h4014;
   localparam int          OAM_SIZE    = 256;

endpackage

// File: rtl/oam_dma.sv
// oam_dma: sprite OAM DMA engine, copies one CPU page into OAM.
// Optional OAM_DMA_STATS_EN adds last_cycles (length of last transfer).
module oam_dma
   import ppu_pkg::*;
#(
   parameter logic [15:0] TRIGGER_ADDR = OAM_DMA_REG,
   parameter int          XFER_LEN     = OAM_SIZE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ce,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data,
   input  logic        cpu_wr,
   input  logic [7:0]  oam_base,
   input  logic [7:0]  mem_data_in,
   output logic        cpu_stall,
   output logic        dma_busy,
   output logic [15:0] dma_addr,
   output logic        dma_rd,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_data,
   output logic        oam_wr_en
`ifdef OAM_DMA_STATS_EN
   ,
   output logic [9:0]  last_cycles
`endif
);

   localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

   dma_state_t state;
   logic [7:0] page;
   logic [7:0] base;
   logic [7:0] idx;
   logic       parity;
   logic       trig;
   logic       last;

`ifdef OAM_DMA_STATS_EN
   logic [9:0] cyc_cnt;
`endif

   assign trig = cpu_wr && (cpu_addr == TRIGGER_ADDR);
   assign last = ({1'b0, idx} == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         page      <= '0;
         base      <= '0;
         idx       <= '0;
         parity    <= 1'b0;
         cpu_stall <= 1'b0;
         dma_busy  <= 1'b0;
         dma_addr  <= '0;
         dma_rd    <= 1'b0;
         oam_addr  <= '0;
         oam_data  <= '0;
         oam_wr_en <= 1'b0;
`ifdef OAM_DMA_STATS_EN
         cyc_cnt     <= '0;
         last_cycles <= '0;
`endif
      end else begin
         // write strobe lasts one clk even when cpu_ce is held high
         oam_wr_en <= 1'b0;
         if (cpu_ce) begin
            parity <= ~parity;
`ifdef OAM_DMA_STATS_EN
            cyc_cnt <= cyc_cnt + 10'd1;
`endif
            unique case (state)
               IDLE: begin
                  if (trig) begin
                     page      <= cpu_data;
                     base      <= oam_base;
                     idx       <= '0;
                     state     <= HALT;
                     cpu_stall <= 1'b1;
                     dma_busy  <= 1'b1;
`ifdef OAM_DMA_STATS_EN
                     cyc_cnt <= 10'd1;
`endif
                  end
               end
               HALT: begin
                  // an even HALT means the following cycle is odd
                  if (parity) begin
                     state    <= READ;
                     dma_rd   <= 1'b1;
                     dma_addr <= {page, idx};
                  end else begin
                     state <= ALIGN;
                  end
               end
               ALIGN: begin
                  state    <= READ;
                  dma_rd   <= 1'b1;
                  dma_addr <= {page, idx};
               end
               READ: begin
                  state     <= WRITE;
                  dma_rd    <= 1'b0;
                  oam_data  <= mem_data_in;
                  oam_addr  <= base + idx;
                  oam_wr_en <= 1'b1;
               end
               WRITE: begin
                  if (last) begin
                     state     <= IDLE;
                     cpu_stall <= 1'b0;
                     dma_busy  <= 1'b0;
`ifdef OAM_DMA_STATS_EN
                     last_cycles <= cyc_cnt;
`endif
                  end else begin
                     idx      <= idx + 8'd1;
                     state    <= READ;
                     dma_rd   <= 1'b1;
                     dma_addr <= {page, idx + 8'd1};
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized directed bench for oam_dma.
// Expected OAM contents and transfer lengths come from a page-copy model.
module tb_oam_dma;

   localparam logic [15:0] TRIG = 16'h4014;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_ce;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic        cpu_wr;
   logic [7:0]  oam_base;
   logic [7:0]  mem_data_in;
   logic        cpu_stall;
   logic        dma_busy;
   logic [15:0] dma_addr;
   logic        dma_rd;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_data;
   logic        oam_wr_en;
`ifdef OAM_DMA_STATS_EN
   logic [9:0]  last_cycles;
`endif

   oam_dma dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_ce      (cpu_ce),
      .cpu_addr    (cpu_addr),
      .cpu_data    (cpu_data),
      .cpu_wr      (cpu_wr),
      .oam_base    (oam_base),
      .mem_data_in (mem_data_in),
      .cpu_stall   (cpu_stall),
      .dma_busy    (dma_busy),
      .dma_addr    (dma_addr),
      .dma_rd      (dma_rd),
      .oam_addr    (oam_addr),
      .oam_data    (oam_data),
      .oam_wr_en   (oam_wr_en)
`ifdef OAM_DMA_STATS_EN
      ,
      .last_cycles (last_cycles)
`endif
   );

   always #5 clk = ~clk;

   // CPU memory: page 02 byte i reads as i^5A, other pages offset
   function automatic logic [7:0] memf(input logic [15:0] a);
      return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'h02);
   endfunction

   assign mem_data_in = memf(dma_addr);

   int total = 0;
   int bad = 0;
   int ncyc = 0;
   int stall_cnt = 0;
   int exp_len = 0;
   logic [7:0] cur_page;
   logic [7:0] cur_base;
   logic [7:0] wa[$];
   logic [7:0] wd[$];
   logic [7:0] oam[256];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic ce, input logic wr,
                       input logic [15:0] a, input logic [7:0] d);
      cpu_ce = ce;
      cpu_wr = wr;
      cpu_addr = a;
      cpu_data = d;
      if (ce && cpu_stall && !rst) stall_cnt++;
      @(posedge clk);
      #2;
      if (ce && !rst) ncyc++;
      if (oam_wr_en) begin
         wa.push_back(oam_addr);
         wd.push_back(oam_data);
         oam[oam_addr] = oam_data;
      end
      cpu_ce = 1'b0;
      cpu_wr = 1'b0;
   endtask

   task automatic cyc(input logic wr, input logic [15:0] a,
                      input logic [7:0] d);
      repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 16'h0, 8'h0);
      tick(1'b1, wr, a, d);
   endtask

   // par: 1 = HALT on odd cycle, 0 = even, other = random
   task automatic start(input logic [7:0] pg, input logic [7:0] bs,
                        input int par);
      int p;
      p = (par == 0 || par == 1) ? par : int'($urandom_range(0, 1));
      if (((ncyc + 1) % 2) != p) cyc(1'b0, 16'h0, 8'h0);
      exp_len = (p == 1) ? 513 : 514;
      cur_page = pg;
      cur_base = bs;
      oam_base = bs;
      wa.delete();
      wd.delete();
      stall_cnt = 0;
      cyc(1'b1, TRIG, pg);
      oam_base = ~bs;
      chk("busy_on", {62'h0, dma_busy, cpu_stall}, 64'h3);
   endtask

   // mode 0 plain, 1 retrigger while busy, 2 cpu_ce freeze, 3 reset at idx 100
   task automatic run(input int mode);
      int n;
      bit hit;
      int chg;
      logic [42:0] snap;
      n = 0;
      hit = 0;
      while (dma_busy && n < 3000) begin
         if (mode == 1 && !hit && wa.size() == 41) begin
            hit = 1;
            cyc(1'b1, TRIG, 8'h33);
         end else if (mode == 2 && !hit && wa.size() >= 60 && dma_rd) begin
            hit = 1;
            chg = 0;
            snap = {dma_addr, dma_rd, oam_addr, oam_data, cpu_stall, dma_busy};
            repeat (50) begin
               tick(1'b0, 1'b0, 16'h0, 8'h0);
               if ({dma_addr, dma_rd, oam_addr, oam_data, cpu_stall, dma_busy}
                   !== snap) chg++;
            end
            chk("freeze_stable", 64'(chg), 64'd0);
         end else if (mode == 3 && !hit && wa.size() == 101) begin
            hit = 1;
            rst = 1'b1;
            #1;
            chk("rst_outs", {28'h0, cpu_stall, dma_busy, dma_addr, dma_rd,
                             oam_addr, oam_data, oam_wr_en}, 64'h0);
            repeat (3) tick(1'b1, 1'b0, 16'h0, 8'h0);
            rst = 1'b0;
            ncyc = 0;
         end else begin
            cyc(1'b0, 16'h0, 8'h0);
         end
         n++;
      end
      chk("done", {63'h0, dma_busy}, 64'h0);
      if (mode == 3) begin
         repeat (30) cyc(1'b0, 16'h0, 8'h0);
         chk("rst_no_more_wr", 64'(wa.size()), 64'd101);
         return;
      end
      if (mode == 1 || mode == 2) chk("event_hit", 64'(hit), 64'd1);
      verify();
   endtask

   task automatic verify();
      int err;
      logic [7:0] i8;
      err = 0;
      chk("n_writes", 64'(wa.size()), 64'd256);
      chk("stall_cycles", 64'(stall_cnt), 64'(exp_len));
`ifdef OAM_DMA_STATS_EN
      chk("last_cycles", 64'(last_cycles), 64'(exp_len));
`endif
      if (wa.size() == 256) begin
         for (int i = 0; i < 256; i++) begin
            i8 = 8'(i);
            if (wa[i] !== 8'(cur_base + i8)) err++;
            if (wd[i] !== memf({cur_page, i8})) err++;
         end
      end
      chk("write_seq", 64'(err), 64'd0);
   endtask

   initial begin
      int err;
      rst = 1'b1;
      cpu_ce = 1'b0;
      cpu_wr = 1'b0;
      cpu_addr = '0;
      cpu_data = '0;
      oam_base = '0;
      for (int i = 0; i < 256; i++) oam[i] = 8'h00;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_outs", {28'h0, cpu_stall, dma_busy, dma_addr, dma_rd,
                         oam_addr, oam_data, oam_wr_en}, 64'h0);
      rst = 1'b0;
      ncyc = 0;
      repeat (3) cyc(1'b0, 16'h0, 8'h0);

      // page 02, HALT odd -> 513 cycles, OAM[i] = i^5A
      start(8'h02, 8'h00, 1);
      run(0);
      err = 0;
      for (int i = 0; i < 256; i++)
         if (oam[i] !== (8'(i) ^ 8'h5A)) err++;
      chk("oam_image", 64'(err), 64'd0);

      // same stimulus, HALT even -> 514 cycles
      start(8'h02, 8'h00, 0);
      run(0);

      // base F0 wrap
      start(8'h07, 8'hF0, 2);
      run(0);
      if (wa.size() == 256) begin
         chk("f0_first_addr", 64'(wa[0]), 64'hF0);
         chk("f0_first_data", 64'(wd[0]), 64'(memf(16'h0700)));
         chk("f0_wrap_addr", 64'(wa[16]), 64'h00);
         chk("f0_wrap_data", 64'(wd[16]), 64'(memf(16'h0710)));
         chk("f0_last_addr", 64'(wa[255]), 64'hEF);
      end

      // page FF must not wrap into page 00
      start(8'hFF, 8'($urandom), 2);
      run(0);

      // retrigger while busy is ignored
      start(8'($urandom_range(0, 254)), 8'($urandom), 2);
      run(1);

      // cpu_ce low for 50 clks mid-READ
      start(8'($urandom), 8'($urandom), 2);
      run(2);

      // reset at idx 100, then a fresh full transfer
      start(8'h11, 8'h22, 2);
      run(3);
      start(8'($urandom), 8'($urandom), 2);
      run(0);

      // trigger on the same clk as rst is lost
      wa.delete();
      rst = 1'b1;
      tick(1'b1, 1'b1, TRIG, 8'h05);
      rst = 1'b0;
      ncyc = 0;
      repeat (10) cyc(1'b0, 16'h0, 8'h0);
      chk("rst_trig_lost", {62'h0, dma_busy, cpu_stall}, 64'h0);
      chk("rst_trig_nowr", 64'(wa.size()), 64'd0);

      // a couple of random transfers
      repeat (2) begin
         start(8'($urandom), 8'($urandom), 2);
         run(0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
